// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one registered 16-bit bitwise logic unit between NREQ requesters.
// Accept in IDLE or on a RESP handshake, compute for one cycle in EXEC, hold the result in RESP.
module logic16_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [16*NREQ-1:0]   req_a,
   input  logic [16*NREQ-1:0]   req_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [15:0]          resp_data,
   output logic [IDW-1:0]       resp_id,
   output logic                 busy
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] id_q;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] winner_next;
   logic           found;
   logic           grant_en;
   logic           accept;
   logic [1:0]     op_q;
   logic [15:0]    a_q, b_q;
   logic [15:0]    result;
   logic [15:0]    resp_data_q;
   logic [IDW-1:0] resp_id_q;

   // First valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      int            idx;
      logic [IDW-1:0] idx_w;
      found = 1'b0;
      winner = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
         idx_w = idx[IDW-1:0];
         if (!found && req_valid[idx_w]) begin
            found = 1'b1;
            winner = idx_w;
         end
      end
   end

   assign winner_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

   // rst_n gates the grant so req_ready drops with reset, not at the next edge.
   assign grant_en = rst_n && ((state_q == StIdle) || ((state_q == StResp) && resp_ready));
   assign accept   = grant_en && found;

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      req_ready = '0;
      if (accept) begin
         req_ready = NREQ'(1) << winner;
         rr_ptr_d  = winner_next;
      end
      case (state_q)
         StIdle:  if (accept) state_d = StExec;
         StExec:  state_d = StResp;
         StResp:  if (resp_ready) state_d = accept ? StExec : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Shared gate arrays, fed only from the registered operands.
   always_comb begin
      result = '0;
      unique case (op_q)
         2'b00: result = a_q & b_q;
         2'b01: result = a_q | b_q;
         2'b10: result = a_q ^ b_q;
         2'b11: result = ~a_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         resp_data_q <= '0;
         resp_id_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         if (accept) begin
            op_q <= req_op[{winner, 1'b0} +: 2];
            a_q  <= req_a[{winner, 4'b0000} +: 16];
            b_q  <= req_b[{winner, 4'b0000} +: 16];
            id_q <= winner;
         end
         if (state_q == StExec) begin
            resp_data_q <= result;
            resp_id_q   <= id_q;
         end
      end
   end

   assign resp_valid = (state_q == StResp);
   assign resp_data  = resp_data_q;
   assign resp_id    = resp_id_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_logic16_arbiter.sv
// Self-checking bench for logic16_arbiter: table of single-requester ops plus
// directed sequences for reset, round-robin, backpressure and wrap/skip.
module tb_logic16_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [7:0]  req_op;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_data;
   logic [1:0]  resp_id;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic16_arbiter #(.NREQ(4), .IDW(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          r;
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int r, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b);
      req_op[2*r +: 2]  = op;
      req_a[16*r +: 16] = a;
      req_b[16*r +: 16] = b;
   endtask

   task automatic clear_reqs();
      req_op = 'x;
      req_a  = 'x;
      req_b  = 'x;
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout: got running expected finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      logic [3:0] exp_rr [6];
      logic [3:0] t6_ord [5];

      vecs[0] = '{0, 2'b01, 16'h00F0, 16'h0F00, 16'h0FF0};
      vecs[1] = '{1, 2'b00, 16'hAAAA, 16'hFFFF, 16'hAAAA};
      vecs[2] = '{1, 2'b01, 16'hAAAA, 16'hFFFF, 16'hFFFF};
      vecs[3] = '{1, 2'b10, 16'hAAAA, 16'hFFFF, 16'h5555};
      vecs[4] = '{1, 2'b11, 16'hAAAA, 16'hFFFF, 16'h5555};
      vecs[5] = '{2, 2'b00, 16'h1234, 16'hFF00, 16'h1200};
      vecs[6] = '{2, 2'b11, 16'h0000, 16'hxxxx, 16'hFFFF};
      vecs[7] = '{3, 2'b10, 16'hF0F0, 16'hFFFF, 16'h0F0F};

      rst_n = 1'b0;
      req_valid = '0;
      resp_ready = 1'b0;
      clear_reqs();
      #3;
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data", 32'(resp_data), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // T1: async reset while holding a result in RESP
      @(negedge clk);
      set_req(2, 2'b00, 16'hFFFF, 16'h1234);
      req_valid = 4'b0100;
      #1 check("t1_grant", 32'(req_ready), 32'b0100);
      @(negedge clk);
      req_valid = '0;
      clear_reqs();
      @(negedge clk);
      check("t1_in_resp", 32'(resp_valid), 32'd1);
      check("t1_data", 32'(resp_data), 32'h1234);
      #2;
      req_valid = 4'b0001;
      set_req(0, 2'b01, 16'h1, 16'h2);
      rst_n = 1'b0;
      #1;
      check("t1_async_valid", 32'(resp_valid), 32'd0);
      check("t1_async_busy", 32'(busy), 32'd0);
      check("t1_async_ready", 32'(req_ready), 32'd0);
      check("t1_async_data", 32'(resp_data), 32'd0);
      @(negedge clk);
      req_valid = '0;
      clear_reqs();
      rst_n = 1'b1;
      @(negedge clk);
      check("t1_after_valid", 32'(resp_valid), 32'd0);
      check("t1_after_busy", 32'(busy), 32'd0);

      // T2/T3: table of single-requester operations; others' operands are X
      for (int v = 0; v < 8; v++) begin
         @(negedge clk);
         set_req(vecs[v].r, vecs[v].op, vecs[v].a, vecs[v].b);
         req_valid = 4'b0001 << vecs[v].r;
         #1 check($sformatf("v%0d_grant", v), 32'(req_ready), 32'(4'b0001 << vecs[v].r));
         @(negedge clk);
         req_valid = '0;
         clear_reqs();
         check($sformatf("v%0d_exec_busy", v), 32'(busy), 32'd1);
         check($sformatf("v%0d_exec_valid", v), 32'(resp_valid), 32'd0);
         @(negedge clk);
         check($sformatf("v%0d_resp_valid", v), 32'(resp_valid), 32'd1);
         check($sformatf("v%0d_data", v), 32'(resp_data), 32'(vecs[v].exp));
         check($sformatf("v%0d_id", v), 32'(resp_id), 32'(vecs[v].r));
         resp_ready = 1'b1;
         @(negedge clk);
         check($sformatf("v%0d_drop", v), 32'(resp_valid), 32'd0);
         check($sformatf("v%0d_idle", v), 32'(busy), 32'd0);
         resp_ready = 1'b0;
      end

      // T4: all four valid, resp_ready high; rr_ptr is 0 after the table
      @(negedge clk);
      for (int i = 0; i < 4; i++) set_req(i, 2'b01, 16'hA0A0 + 16'(i), 16'h0000);
      req_valid = 4'b1111;
      resp_ready = 1'b1;
      #1 check("t4_first_grant", 32'(req_ready), 32'b0001);
      for (int g = 0; g < 5; g++) exp_rr[g] = 4'(g % 4);
      exp_rr[5] = 4'd1;
      for (int g = 0; g < 5; g++) begin
         @(negedge clk);
         check($sformatf("t4_exec_ready%0d", g), 32'(req_ready), 32'd0);
         check($sformatf("t4_exec_valid%0d", g), 32'(resp_valid), 32'd0);
         @(negedge clk);
         check($sformatf("t4_valid%0d", g), 32'(resp_valid), 32'd1);
         check($sformatf("t4_id%0d", g), 32'(resp_id), 32'(exp_rr[g]));
         check($sformatf("t4_data%0d", g), 32'(resp_data), 32'(16'hA0A0 + 16'(exp_rr[g])));
         check($sformatf("t4_grant%0d", g), 32'(req_ready), 32'(4'b0001 << exp_rr[g+1]));
      end
      req_valid = '0;
      clear_reqs();
      @(negedge clk);
      check("t4_idle", 32'(busy), 32'd0);
      resp_ready = 1'b0;

      // T5: backpressure; rr_ptr is 1 here
      @(negedge clk);
      set_req(1, 2'b01, 16'h5A5A, 16'h0000);
      req_valid = 4'b0010;
      #1 check("t5_grant1", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = '0;
      clear_reqs();
      @(negedge clk);
      set_req(2, 2'b11, 16'h00FF, 16'hxxxx);
      req_valid = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("t5_hold_valid%0d", c), 32'(resp_valid), 32'd1);
         check($sformatf("t5_hold_data%0d", c), 32'(resp_data), 32'h5A5A);
         check($sformatf("t5_hold_id%0d", c), 32'(resp_id), 32'd1);
         check($sformatf("t5_hold_ready%0d", c), 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      #1 check("t5_release_grant", 32'(req_ready), 32'b0100);
      @(negedge clk);
      req_valid = '0;
      clear_reqs();
      check("t5_exec_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("t5_resp_data", 32'(resp_data), 32'hFF00);
      check("t5_resp_id", 32'(resp_id), 32'd2);
      @(negedge clk);
      check("t5_idle", 32'(busy), 32'd0);
      resp_ready = 1'b0;

      // T6: rr_ptr is 3, only req3 and req1 valid
      @(negedge clk);
      set_req(1, 2'b00, 16'h1111, 16'hFFFF);
      set_req(3, 2'b00, 16'h3333, 16'hFFFF);
      req_valid = 4'b1010;
      resp_ready = 1'b1;
      t6_ord[0] = 4'd3; t6_ord[1] = 4'd1; t6_ord[2] = 4'd3; t6_ord[3] = 4'd1; t6_ord[4] = 4'd3;
      #1 check("t6_first_grant", 32'(req_ready), 32'b1000);
      for (int g = 0; g < 4; g++) begin
         @(negedge clk);
         check($sformatf("t6_exec_ready%0d", g), 32'(req_ready), 32'd0);
         @(negedge clk);
         check($sformatf("t6_id%0d", g), 32'(resp_id), 32'(t6_ord[g]));
         check($sformatf("t6_data%0d", g), 32'(resp_data),
               (t6_ord[g] == 4'd1) ? 32'h1111 : 32'h3333);
         check($sformatf("t6_grant%0d", g), 32'(req_ready), 32'(4'b0001 << t6_ord[g+1]));
      end
      req_valid = '0;
      clear_reqs();
      @(negedge clk);
      check("t6_idle", 32'(busy), 32'd0);
      resp_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
